merlin_imem: RTL and testbench
==============================

Name: merlin_imem

Overview:
- Tightly coupled instruction memory that sits directly upstream of the core's instruction port and serves the ireq/irsp fetch handshake.
- Word-organised synchronous SRAM with a fixed base address and a 2-entry in-order response queue, so fetch back-pressure never loses read data.
- A loader write port (boot/debug) fills the array and pre-empts fetches.

Parameters:
- C_BASE_ADDR, 32'h0, byte address of word 0; must be aligned to the array size.
- C_DEPTH_X, 10, base-2 exponent of the array depth in 32-bit words (default 1024 words / 4 KiB).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- ireqready_o  out  1  fetch request can be accepted this cycle.
- ireqvalid_i  in  1  fetch request valid.
- ireqhpl_i  in  2  HART privilege level of the request; accepted and ignored.
- ireqaddr_i  in  32  fetch byte address.
- irspready_i  in  1  consumer accepts the response.
- irspvalid_o  out  1  response valid.
- irsprerr_o  out  1  response is a read error.
- irspdata_o  out  32  instruction word.
- ldwr_i  in  1  loader write strobe.
- ldaddr_i  in  C_DEPTH_X  loader word index.
- lddata_i  in  32  loader write data.

Behaviour:
- Reset: irspvalid_o=0, irsprerr_o=0, irspdata_o=0, ireqready_o=0 during the reset cycle; queue and in-flight flag cleared. Array contents are not reset.
- Accept: a fetch is accepted when ireqvalid_i & ireqready_o. ireqready_o = !reset_i & !ldwr_i & (pending<2).
  - pending = queued entries + in-flight read.
  - A pop in the same cycle gives no credit.
- In range: addr-C_BASE_ADDR < 4*2^C_DEPTH_X. Index = (addr-C_BASE_ADDR)[C_DEPTH_X+1:2].
- Error response: an out-of-range address or addr[1:0]!=0 gives rerr=1, data=32'h0. No SRAM read is issued, but the request still occupies a queue slot and keeps ordering.
- Latency: a request accepted in cycle N presents its response in cycle N+1 if nothing older is pending. Otherwise it is presented after all older responses, strictly in order.
- Holding: the response holds (valid, rerr, data all stable) until irspready_i. Pop happens at the clock edge where irspvalid_o & irspready_i.
- Queue: 2 entries of {rerr, data}, circular read/write pointers with wrap-around.
  - SRAM data is captured into the queue in the cycle after the read, unless it is popped that cycle.
  - Throughput is 1 fetch/cycle while irspready_i stays high.
- Loader:
  - ldwr_i writes lddata_i to the array at ldaddr_i in that cycle and forces ireqready_o=0.
  - Reads already in flight or queued complete unaffected.
  - A fetch accepted in cycle M+1 observes a write made in cycle M.
- Simultaneous push and pop with pending=2: allowed. The count is unchanged and the pointers advance.
- Reset mid-operation: all queued and in-flight responses are discarded. irspvalid_o=0 in the cycle after reset_i.

Test Plan:
- Reset, loader writes 0x00000013 to index 0 and 0x00100093 to index 1; fetch 0x0 then 0x4 back-to-back with irspready_i=1 -> responses in cycles N+1 and N+2: 0x00000013 then 0x00100093, rerr=0.
- irspready_i=0, issue 3 fetches -> only 2 accepted, ireqready_o=0 with pending=2; release irspready_i -> both responses in order, then the 3rd is accepted.
- Fetch 0x2 and fetch C_BASE_ADDR+0x1000 (default params) -> each gives rerr=1, data=0, in order with surrounding good fetches.
- ldwr_i held high while ireqvalid_i=1 -> ireqready_o=0; release ldwr_i, fetch the written word -> new data returned.
- Random valid/ready stall pattern over 1000 fetches against a reference model -> no drop, duplicate or reorder; irsp outputs stable while stalled.
- Assert reset_i with 2 responses pending -> irspvalid_o=0 next cycle; the next accepted fetch returns correct data at N+1.

Source files
------------

// File: rtl/merlin_imem.sv
// ---------------------------------------------------------------------------
// merlin_imem: tightly coupled instruction SRAM serving the ireq/irsp fetch port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module merlin_imem #(
   parameter logic [31:0] C_BASE_ADDR = 32'h0,
   parameter int          C_DEPTH_X   = 10
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   output logic                 ireqready_o,
   input  logic                 ireqvalid_i,
   input  logic [1:0]           ireqhpl_i,
   input  logic [31:0]          ireqaddr_i,
   input  logic                 irspready_i,
   output logic                 irspvalid_o,
   output logic                 irsprerr_o,
   output logic [31:0]          irspdata_o,
   input  logic                 ldwr_i,
   input  logic [C_DEPTH_X-1:0] ldaddr_i,
   input  logic [31:0]          lddata_i
);

   localparam int C_WORDS = 1 << C_DEPTH_X;

   logic [31:0] mem [C_WORDS];
   logic [31:0] sram_rdata_q;

   logic        inflight_q, inflight_d;
   logic        inflight_err_q, inflight_err_d;
   logic [31:0] q_data_q [2];
   logic [31:0] q_data_d [2];
   logic        q_err_q [2];
   logic        q_err_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   logic [31:0]          off;
   logic                 in_range;
   logic                 aligned;
   logic [C_DEPTH_X-1:0] rd_idx;
   logic [1:0]           pending;
   logic                 accept;
   logic                 rd_en;
   logic                 from_q;
   logic                 pop;
   logic                 push;
   logic                 head_err;
   logic [31:0]          head_data;
   logic [31:0]          inflight_data;
   logic                 unused_bits;

   assign off      = ireqaddr_i - C_BASE_ADDR;
   assign in_range = (off[31:C_DEPTH_X+2] == '0);
   assign aligned  = (ireqaddr_i[1:0] == 2'b00);
   assign rd_idx   = off[C_DEPTH_X+1:2];

   assign unused_bits = ^{ireqhpl_i, off[1:0]};

   // Pending counts every accepted response not yet popped, including the read in flight.
   assign pending     = count_q + {1'b0, inflight_q};
   assign ireqready_o = !reset_i && !ldwr_i && (pending < 2'd2);
   assign accept      = ireqvalid_i && ireqready_o;
   assign rd_en       = accept && in_range && aligned;

   assign from_q        = (count_q != 2'd0);
   assign inflight_data = inflight_err_q ? 32'h0 : sram_rdata_q;
   assign head_err      = from_q ? q_err_q[rd_ptr_q]  : inflight_err_q;
   assign head_data     = from_q ? q_data_q[rd_ptr_q] : inflight_data;

   assign irspvalid_o = !reset_i && (from_q || inflight_q);
   assign irsprerr_o  = irspvalid_o && head_err;
   assign irspdata_o  = irspvalid_o ? head_data : 32'h0;

   assign pop  = irspvalid_o && irspready_i;
   // The in-flight word bypasses the queue only when it is popped straight away.
   assign push = inflight_q && !(pop && !from_q);

   always_comb begin
      inflight_d     = accept;
      inflight_err_d = accept && !(in_range && aligned);
      q_data_d       = q_data_q;
      q_err_d        = q_err_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      if (push) begin
         q_data_d[wr_ptr_q] = inflight_data;
         q_err_d[wr_ptr_q]  = inflight_err_q;
         wr_ptr_d           = ~wr_ptr_q;
      end
      if (pop && from_q) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop && from_q})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         inflight_q     <= 1'b0;
         inflight_err_q <= 1'b0;
         q_data_q[0]    <= 32'h0;
         q_data_q[1]    <= 32'h0;
         q_err_q[0]     <= 1'b0;
         q_err_q[1]     <= 1'b0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
      end else begin
         inflight_q     <= inflight_d;
         inflight_err_q <= inflight_err_d;
         q_data_q       <= q_data_d;
         q_err_q        <= q_err_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
      end
   end

   // Array contents survive reset; loader writes and fetch reads never share a cycle.
   always_ff @(posedge clk_i) begin
      if (ldwr_i) begin
         mem[ldaddr_i] <= lddata_i;
      end
      if (rd_en) begin
         sram_rdata_q <= mem[rd_idx];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_merlin_imem.sv
// ---------------------------------------------------------------------------
// tb_merlin_imem: directed table plus randomized fetch traffic against a queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_merlin_imem;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        ireqready_o;
   logic        ireqvalid_i = 1'b0;
   logic [1:0]  ireqhpl_i = 2'b11;
   logic [31:0] ireqaddr_i = 32'h0;
   logic        irspready_i = 1'b0;
   logic        irspvalid_o;
   logic        irsprerr_o;
   logic [31:0] irspdata_o;
   logic        ldwr_i = 1'b0;
   logic [9:0]  ldaddr_i = 10'h0;
   logic [31:0] lddata_i = 32'h0;

   always #5 clk_i = ~clk_i;

   merlin_imem dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .ireqready_o (ireqready_o),
      .ireqvalid_i (ireqvalid_i),
      .ireqhpl_i   (ireqhpl_i),
      .ireqaddr_i  (ireqaddr_i),
      .irspready_i (irspready_i),
      .irspvalid_o (irspvalid_o),
      .irsprerr_o  (irsprerr_o),
      .irspdata_o  (irspdata_o),
      .ldwr_i      (ldwr_i),
      .ldaddr_i    (ldaddr_i),
      .lddata_i    (lddata_i)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        err;
      logic [31:0] data;
   } rsp_t;

   rsp_t        mq[$];
   logic [31:0] mmem [1024];
   int          m_acc = 0;

   logic        s_ready, s_valid, s_err;
   logic [31:0] s_data;

   typedef struct {
      logic        rst;
      logic        ld;
      logic [9:0]  la;
      logic [31:0] ldd;
      logic        rv;
      logic [31:0] ra;
      logic        rr;
      logic        e_ready;
      logic        e_valid;
      logic        e_err;
      logic [31:0] e_data;
   } vec_t;

   vec_t vt[13];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: every accepted fetch's response is fixed at acceptance and delivered FIFO.
   task automatic step(input logic rst, input logic ld, input logic [9:0] la,
                       input logic [31:0] ldd, input logic rv, input logic [31:0] ra,
                       input logic rr);
      logic        e_ready, e_valid, e_err, acc, pp;
      logic [31:0] e_data, o;
      rsp_t        r;
      reset_i     = rst;
      ldwr_i      = ld;
      ldaddr_i    = la;
      lddata_i    = ldd;
      ireqvalid_i = rv;
      ireqaddr_i  = ra;
      irspready_i = rr;
      ireqhpl_i   = 2'($urandom_range(0, 3));
      @(negedge clk_i);
      s_ready = ireqready_o;
      s_valid = irspvalid_o;
      s_err   = irsprerr_o;
      s_data  = irspdata_o;
      e_ready = !rst && !ld && (mq.size() < 2);
      e_valid = !rst && (mq.size() > 0);
      e_err   = e_valid ? mq[0].err : 1'b0;
      e_data  = e_valid ? mq[0].data : 32'h0;
      cmp("ireqready", {31'h0, s_ready}, {31'h0, e_ready});
      cmp("irspvalid", {31'h0, s_valid}, {31'h0, e_valid});
      if (e_valid || rst) begin
         cmp("irsprerr", {31'h0, s_err}, {31'h0, e_err});
         cmp("irspdata", s_data, e_data);
      end
      acc = rv && e_ready;
      pp  = e_valid && rr;
      if (rst) begin
         mq.delete();
      end else begin
         if (pp) void'(mq.pop_front());
         if (acc) begin
            o      = ra;
            r.err  = (ra[1:0] != 2'b00) || (o >= 32'h1000);
            r.data = r.err ? 32'h0 : mmem[o[11:2]];
            mq.push_back(r);
            m_acc++;
         end
         if (ld) mmem[la] = ldd;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 32'h0, rr);
   endtask

   task automatic fetch(input logic [31:0] a, input logic rr);
      step(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, a, rr);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int start;
      int guard;
      logic [31:0] a;
      logic [2:0]  kind;

      for (int i = 0; i < 1024; i++) mmem[i] = 32'h0;

      //          rst   ld    la     ldd           rv    ra            rr    rdy   vld   err   data
      vt[0]  = '{1'b1, 1'b0, 10'd0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      vt[1]  = '{1'b0, 1'b1, 10'd0, 32'h00000013, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      vt[2]  = '{1'b0, 1'b1, 10'd1, 32'h00100093, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      vt[3]  = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[4]  = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 32'h4,        1'b1, 1'b1, 1'b1, 1'b0, 32'h00000013};
      vt[5]  = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h00100093};
      vt[6]  = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[7]  = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 32'h2,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[8]  = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
      vt[9]  = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 32'h1000,     1'b1, 1'b1, 1'b1, 1'b0, 32'h00000013};
      vt[10] = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b1, 32'h4,        1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
      vt[11] = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h00100093};
      vt[12] = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

      for (int i = 0; i < 13; i++) begin
         step(vt[i].rst, vt[i].ld, vt[i].la, vt[i].ldd, vt[i].rv, vt[i].ra, vt[i].rr);
         cmp($sformatf("vec%0d_ready", i), {31'h0, s_ready}, {31'h0, vt[i].e_ready});
         cmp($sformatf("vec%0d_valid", i), {31'h0, s_valid}, {31'h0, vt[i].e_valid});
         if (vt[i].e_valid || vt[i].rst) begin
            cmp($sformatf("vec%0d_rerr", i), {31'h0, s_err}, {31'h0, vt[i].e_err});
            cmp($sformatf("vec%0d_data", i), s_data, vt[i].e_data);
         end
      end

      // Preload a 64-word region used by the remaining sequences.
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 1'b1, 10'(i), $urandom, 1'b0, 32'h0, 1'b1);
      end

      // Back-pressure: third fetch waits until a slot frees, pop gives no same-cycle credit.
      fetch(32'h0, 1'b0);
      fetch(32'h4, 1'b0);
      fetch(32'h8, 1'b0);
      cmp("bp_full_ready", {31'h0, s_ready}, 32'h0);
      fetch(32'h8, 1'b1);
      cmp("bp_pop_no_credit", {31'h0, s_ready}, 32'h0);
      cmp("bp_first_data", s_data, mmem[0]);
      fetch(32'h8, 1'b1);
      cmp("bp_third_accept", {31'h0, s_ready}, 32'h1);
      cmp("bp_second_data", s_data, mmem[1]);
      idle(1'b1);
      cmp("bp_third_data", s_data, mmem[2]);
      idle(1'b1);

      // Loader pre-empts fetches; a fetch in the following cycle sees the new word.
      step(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 1'b1, 32'h14, 1'b1);
      cmp("ld_blocks_ready", {31'h0, s_ready}, 32'h0);
      step(1'b0, 1'b1, 10'd5, 32'hCAFEF00D, 1'b1, 32'h14, 1'b1);
      cmp("ld_blocks_ready2", {31'h0, s_ready}, 32'h0);
      fetch(32'h14, 1'b1);
      idle(1'b1);
      cmp("ld_new_data", s_data, 32'hCAFEF00D);

      // Reset with two responses pending discards them.
      fetch(32'h0, 1'b0);
      fetch(32'h4, 1'b0);
      step(1'b1, 1'b0, 10'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle(1'b0);
      cmp("rst_discard_valid", {31'h0, s_valid}, 32'h0);
      fetch(32'h8, 1'b1);
      idle(1'b1);
      cmp("rst_after_valid", {31'h0, s_valid}, 32'h1);
      cmp("rst_after_data", s_data, mmem[2]);

      // Random traffic: 1000 accepted fetches with random stalls and occasional loader writes.
      start = m_acc;
      guard = 0;
      while ((m_acc - start) < 1000 && guard < 20000) begin
         guard++;
         if ($urandom_range(0, 15) == 0) begin
            step(1'b0, 1'b1, 10'($urandom_range(0, 63)), $urandom,
                 1'b1, 32'h0, 1'($urandom_range(0, 1)));
         end else begin
            kind = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 63)) * 32'd4;
            if (kind == 3'd0) a = a + 32'($urandom_range(1, 3));
            else if (kind == 3'd1) a = 32'h1000 + a;
            else if (kind == 3'd2) a = 32'hFFFF_FFFC;
            step(1'b0, 1'b0, 10'h0, 32'h0, 1'($urandom_range(0, 3) != 0), a,
                 1'($urandom_range(0, 2) != 0));
         end
      end
      cmp("rand_accepted", 32'(m_acc - start), 32'd1000);
      guard = 0;
      while (mq.size() > 0 && guard < 10) begin
         guard++;
         idle(1'b1);
      end
      cmp("rand_drained", 32'(mq.size()), 32'd0);
      idle(1'b1);
      cmp("final_idle_valid", {31'h0, s_valid}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
